// File: rtl/fp_mul_arbiter.sv
// ============================================================================
// fp_mul_arbiter : round-robin sharing of one FP multiplier by two requesters.
// Optional WAIT abort via `define FPM_TIMEOUT_EN.     Revision: 1.0
// ============================================================================
`default_nettype none

module fp_mul_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [31:0] res,
   output logic        res_valid0,
   output logic        res_valid1,
   output logic        res_err,
   output logic        mul_start,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_res,
   input  logic        mul_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fp_mul_arbiter: TIMEOUT must be at least 1");
   end

   state_t      state_q, state_d;
   logic        last_q, last_d;      // last requester served: 0 or 1
   logic        owner_q, owner_d;    // requester of the operation in flight
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic        gnt0_q, gnt0_d;
   logic        gnt1_q, gnt1_d;
   logic [31:0] res_q, res_d;
   logic        rv0_q, rv0_d;
   logic        rv1_q, rv1_d;
   logic        w_pick1;

`ifdef FPM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   // Requester 1 wins when alone, or on a tie when requester 0 was served last.
   assign w_pick1 = req1 && (!req0 || !last_q);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      res_d   = res_q;
      rv0_d   = 1'b0;
      rv1_d   = 1'b0;
`ifdef FPM_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               owner_d = w_pick1;
               last_d  = w_pick1;
               opa_d   = w_pick1 ? a1 : a0;
               opb_d   = w_pick1 ? b1 : b0;
               gnt0_d  = !w_pick1;
               gnt1_d  = w_pick1;
               state_d = S_START;
            end
         end
         S_START: begin
`ifdef FPM_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mul_done) begin
               res_d   = mul_res;
               rv0_d   = !owner_q;
               rv1_d   = owner_q;
               state_d = S_DONE;
            end
`ifdef FPM_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT - 1)) begin
               res_d   = C_QNAN;
               err_d   = 1'b1;
               rv0_d   = !owner_q;
               rv1_d   = owner_q;
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         res_q   <= '0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         res_q   <= res_d;
         rv0_q   <= rv0_d;
         rv1_q   <= rv1_d;
      end
   end

`ifdef FPM_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign res_err = err_q;
`else
   assign res_err = 1'b0;
`endif

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign res        = res_q;
   assign res_valid0 = rv0_q;
   assign res_valid1 = rv1_q;
   assign mul_start  = (state_q == S_START);
   assign mul_a      = opa_q;
   assign mul_b      = opb_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter; the multiplier model raises
// mul_done five cycles after mul_start.
`default_nettype none

module tb_fp_mul_arbiter;

   localparam logic [31:0] C_A0  = 32'h416C_A3D7;
   localparam logic [31:0] C_B0  = 32'hC2C4_428F;
   localparam logic [31:0] C_P0  = 32'hC4B5_6AF7;
   localparam logic [31:0] C_A1  = 32'h3F80_0000;
   localparam logic [31:0] C_B1  = 32'h4000_0000;
   localparam logic [31:0] C_P1  = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        gnt0, gnt1, res_valid0, res_valid1, res_err, mul_start, mul_done;
   logic [31:0] res, mul_a, mul_b;
   logic [31:0] mdl_res = '0;
   logic        mdl_done = 1'b0;
   logic        mdl_busy = 1'b0;
   int          mdl_cnt = 0;
   logic        mdl_off = 1'b0;
   logic        done_ovr = 1'b0;

   int          n_chk = 0, n_pass = 0;
   int          n_rv = 0, n_both = 0, n_start = 0;
   int          gq[$];
   logic [32:0] rq[$];

   always #5 clk = ~clk;

   fp_mul_arbiter #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .res(res), .res_valid0(res_valid0), .res_valid1(res_valid1), .res_err(res_err),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_res(mdl_res), .mul_done(mul_done)
   );

   function automatic logic [31:0] mdl(input logic [31:0] a, input logic [31:0] b);
      if (a == C_A0 && b == C_B0) return C_P0;
      if (a == C_A1 && b == C_B1) return C_P1;
      return 32'hDEAD_BEEF;
   endfunction

   assign mul_done = mdl_done | done_ovr;

   always @(posedge clk) begin
      mdl_done <= 1'b0;
      if (!rst) begin
         mdl_busy <= 1'b0;
         mdl_cnt  <= 0;
      end else if (mul_start) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= 1;
      end else if (mdl_busy) begin
         if (mdl_cnt == 4) begin
            mdl_busy <= 1'b0;
            if (!mdl_off) begin
               mdl_done <= 1'b1;
               mdl_res  <= mdl(mul_a, mul_b);
            end
         end else begin
            mdl_cnt <= mdl_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (gnt0) gq.push_back(0);
         if (gnt1) gq.push_back(1);
         if (res_valid0) rq.push_back({1'b0, res});
         if (res_valid1) rq.push_back({1'b1, res});
         if (res_valid0 || res_valid1) n_rv++;
         if (mul_start) n_start++;
         if ((gnt0 && gnt1) || (res_valid0 && res_valid1)) n_both++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic wait_gnt(input bit who, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(who ? gnt1 : gnt0) && lat < 40);
   endtask

   task automatic wait_rv(input bit who, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(who ? res_valid1 : res_valid0) && lat < 40);
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int guard;
      int rv_before;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_res", res, 32'h0);
      chk("rst_mul_a", mul_a, 32'h0);
      chk("rst_mul_b", mul_b, 32'h0);
      chk("rst_ctrl", 32'({gnt0, gnt1, res_valid0, res_valid1, res_err, mul_start}), 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // single request, operand changes during WAIT
      req0 = 1'b1; a0 = C_A0; b0 = C_B0;
      wait_gnt(1'b0, lat);
      req0 = 1'b0;
      chk("gnt0_lat", 32'(lat), 32'd1);
      chk("start_with_gnt", 32'(mul_start), 32'd1);
      @(negedge clk);
      a0 = '0; b0 = '0;
      chk("start_one_cycle", 32'(mul_start), 32'd0);
      @(negedge clk);
      chk("mul_a_held", mul_a, C_A0);
      chk("mul_b_held", mul_b, C_B0);
      wait_rv(1'b0, lat);
      chk("rv0_lat", 32'(lat), 32'd4);
      chk("res_first", res, C_P0);
      chk("err_first", 32'(res_err), 32'd0);
      chk("rv1_quiet", 32'(res_valid1), 32'd0);
      chk("start_count", 32'(n_start), 32'd1);
      @(negedge clk);
      chk("rv0_pulse", 32'(res_valid0), 32'd0);

      // both requesting from reset: strict alternation starting with 0
      do_reset();
      gq.delete();
      rq.delete();
      a0 = C_A0; b0 = C_B0; a1 = C_A1; b1 = C_B1;
      req0 = 1'b1; req1 = 1'b1;
      guard = 0;
      while (rq.size() < 4 && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("rr_done", 32'(guard < 200), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("rr_gnt", (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(i % 2));
         chk("rr_rv_id", (i < rq.size()) ? 32'(rq[i][32]) : 32'hFFFF_FFFF, 32'(i % 2));
         chk("rr_res", (i < rq.size()) ? rq[i][31:0] : 32'hFFFF_FFFF, (i % 2 == 0) ? C_P0 : C_P1);
      end
      repeat (12) @(negedge clk);

      // reset mid-operation
      req0 = 1'b1; a0 = C_A0; b0 = C_B0;
      wait_gnt(1'b0, lat);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      rv_before = n_rv;
      rst = 1'b0;
      #1;
      chk("arst_res", res, 32'h0);
      chk("arst_mul_a", mul_a, 32'h0);
      chk("arst_mul_b", mul_b, 32'h0);
      chk("arst_ctrl", 32'({gnt0, gnt1, res_valid0, res_valid1, res_err, mul_start}), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("arst_no_rv", 32'(n_rv - rv_before), 32'd0);
      req0 = 1'b1;
      wait_gnt(1'b0, lat);
      req0 = 1'b0;
      chk("post_rst_gnt_lat", 32'(lat), 32'd1);
      wait_rv(1'b0, lat);
      chk("post_rst_rv_lat", 32'(lat), 32'd6);
      chk("post_rst_res", res, C_P0);

      // mul_done high during START must be ignored
      @(negedge clk);
      req1 = 1'b1; a1 = C_A1; b1 = C_B1;
      wait_gnt(1'b1, lat);
      req1 = 1'b0;
      chk("gnt1_lat", 32'(lat), 32'd1);
      done_ovr = 1'b1;
      @(negedge clk);
      done_ovr = 1'b0;
      chk("start_done_ignored", 32'(res_valid1), 32'd0);
      wait_rv(1'b1, lat);
      chk("rv1_lat", 32'(lat), 32'd5);
      chk("res_second", res, C_P1);

`ifdef FPM_TIMEOUT_EN
      // multiplier never answers: abort with qNaN after TIMEOUT WAIT cycles
      @(negedge clk);
      mdl_off = 1'b1;
      req0 = 1'b1; a0 = C_A0; b0 = C_B0;
      wait_gnt(1'b0, lat);
      req0 = 1'b0;
      wait_rv(1'b0, lat);
      mdl_off = 1'b0;
      chk("to_rv_lat", 32'(lat), 32'd9);
      chk("to_res", res, 32'h7FC0_0000);
      chk("to_err", 32'(res_err), 32'd1);
      req0 = 1'b1;
      wait_gnt(1'b0, lat);
      req0 = 1'b0;
      chk("to_back_idle", 32'(lat), 32'd2);
      chk("to_err_clear", 32'(res_err), 32'd0);
      wait_rv(1'b0, lat);
      chk("to_next_res", res, C_P0);
`endif

      chk("no_overlap", 32'(n_both), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 64, max WAIT cycles before abort (used only with FPM_TIMEOUT_EN).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  requester 0/1 operation request, held until its grant.
- a0, b0 / a1, b1  in  32  requester 0/1 IEEE-754 single operands, stable while req high.
- gnt0 / gnt1  out  1  one-cycle pulse: operands accepted.
- res  out  32  product of last completed operation, held until next completion.
- res_valid0 / res_valid1  out  1  one-cycle pulse: res belongs to requester 0/1.
- res_err  out  1  high with res_validX when operation aborted.
- mul_start  out  1  one-cycle start pulse to the shared FP multiplier.
- mul_a, mul_b  out  32  multiplier operands.
- mul_res  in  32  multiplier result.
- mul_done  in  1  multiplier completion.

Function
REQ-003 SHALL share one FP multiplier between two requesters, one operation in flight at a time.
REQ-004 SHALL implement FSM: IDLE, START, WAIT, DONE; all outputs registered or decoded from state only.
REQ-005 IDLE: if any req sampled high, SHALL select winner, latch its a/b into operand regs, pulse gntX next cycle, go START; else stay IDLE.
REQ-006 Arbitration SHALL be round-robin on a last-served pointer: single request wins; both requesting -> requester not last served wins; pointer updates on grant.
REQ-007 START: mul_start SHALL be 1 for exactly this one cycle; next state WAIT unconditionally; mul_done ignored in START.
REQ-008 mul_a/mul_b SHALL equal latched operands from START through DONE, unaffected by requester input changes after grant.
REQ-009 WAIT: on mul_done sampled 1, SHALL register res<=mul_res, pulse res_validX of granted requester, go DONE.
REQ-010 DONE: SHALL last one cycle, then IDLE; requests not evaluated in START, WAIT, DONE.
REQ-011 Latency: req high at edge k -> gnt at cycle k+1, mul_start at k+1, res_valid one cycle after the edge sampling mul_done; back-to-back grants separated by at least one IDLE cycle.
REQ-012 A requester deasserting req before grant SHALL simply not be granted; req held after grant is treated as a new request at next IDLE.
REQ-013 gnt0/gnt1 and res_valid0/res_valid1 SHALL never be high simultaneously.

Reset
REQ-014 rst low SHALL asynchronously force IDLE, pointer = requester 1 (so requester 0 wins first tie), and all outputs 0 including res, mul_a, mul_b.
REQ-015 Reset mid-operation SHALL drop the in-flight operation with no res_valid issued; mul_start deasserts immediately.

Configuration
REQ-016 Macro FPM_TIMEOUT_EN defined: a cycle counter SHALL run in WAIT; if mul_done not seen within TIMEOUT cycles, SHALL go DONE with res=32'h7FC00000 (qNaN), res_err=1, res_validX pulsed; counter clears on entering WAIT.
REQ-017 Macro undefined: no counter, res_err tied 0, WAIT persists until mul_done.

Verification
(Bench model: multiplier asserting mul_done 5 cycles after mul_start.)
REQ-018 req0 with a0=32'h416CA3D7, b0=32'hC2C4428F -> gnt0 pulse, one mul_start, res=32'hC4B56AF7 with res_valid0, res_err=0.
REQ-019 req0 and req1 raised same edge, both held -> grants gnt0, gnt1, gnt0, ... alternating; res_valid matches granted requester each time.
REQ-020 Change a0/b0 to 0 during WAIT -> mul_a/mul_b unchanged, result still 32'hC4B56AF7.
REQ-021 rst low two cycles after mul_start -> all outputs 0 at once, no res_valid; after release, first req0 completes normally.
REQ-022 FPM_TIMEOUT_EN, TIMEOUT=8, model never asserts mul_done -> res=32'h7FC00000, res_err=1, res_valid pulse 8 cycles into WAIT; FSM back to IDLE.
REQ-023 mul_done held high during START -> ignored; transition to DONE only from WAIT.
